uart_rx_fifo: RTL

Parametrised UART receiver with a buffered output: oversamples `RxD`, validates start bits, and assembles frames of configurable width with optional even/odd parity. Each completed frame and its error flags go into an on-chip FIFO that the consumer pops with a read strobe. It replaces the single-register receive path in front of the LED display and CPU-side consumers, so bursts of frames are no longer lost.

---
 rtl/uart_pkg.sv | 37 +++
 rtl/uart_sync_fifo.sv | 82 ++++++++
 rtl/uart_rx_fifo.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: FSM state encodings, parity mode codes and baud divisor helpers
// shared by the uart_rx_fifo receiver.
package uart_pkg;

    localparam int unsigned DIV_W = 20;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Modes 0 and 3 both mean "no parity bit on the line"
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    function automatic int unsigned baud_rate(input logic [2:0] sel);
        case (sel)
            3'd0:    return 300;
            3'd1:    return 1200;
            3'd2:    return 4800;
            3'd3:    return 9600;
            3'd4:    return 19200;
            3'd5:    return 38400;
            3'd6:    return 57600;
            default: return 115200;
        endcase
    endfunction

    // Rounded clocks per 16x oversample tick
    function automatic logic [DIV_W-1:0] baud_div(input int unsigned clk_hz, input logic [2:0] sel);
        int unsigned rate;
        rate = baud_rate(sel);
        return DIV_W'((clk_hz + 8 * rate) / (16 * rate));
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock first-word fall-through FIFO with level count,
// registered head/valid/level outputs and simultaneous push/pop at any level.
module uart_sync_fifo
#(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_wr,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_rd,
    output logic [WIDTH-1:0]       o_rdata,
    output logic                   o_valid,
    output logic                   o_full_c,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [LVL_W-1:0] r_level;
    logic [LVL_W-1:0] w_level_nxt;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] w_head_nxt;
    logic             r_valid;
    logic             w_full;
    logic             w_pop;
    logic             w_push;

    assign w_full = (r_level == LVL_W'(DEPTH));
    assign w_pop  = i_rd & r_valid;
    assign w_push = i_wr & (~w_full | w_pop);

    // Head register is preloaded with whatever will sit at the read pointer after this edge
    always_comb begin
        w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_pop);
        w_level_nxt  = r_level + LVL_W'(w_push) - LVL_W'(w_pop);
        if (w_level_nxt == '0) begin
            w_head_nxt = '0;
        end else if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
            w_head_nxt = i_wdata;
        end else begin
            w_head_nxt = r_mem[w_rd_ptr_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_head   <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_push);
            r_rd_ptr <= w_rd_ptr_nxt;
            r_level  <= w_level_nxt;
            r_head   <= w_head_nxt;
            r_valid  <= (w_level_nxt != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    assign o_rdata  = r_head;
    assign o_valid  = r_valid;
    assign o_full_c = w_full;
    assign o_level  = r_level;

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x oversampling UART receiver writing {ferror, perror, data} into a FIFO.
// Define UART_RX_MAJORITY_EN to vote each bit over ticks 7, 8, 9 instead of sampling tick 8.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned DEPTH     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   Rx_EN,
    input  logic [2:0]             baud_select,
    input  logic [1:0]             parity_mode,
    input  logic                   RxD,
    input  logic                   Rx_RD,
    output logic [DATA_BITS-1:0]   Rx_DATA,
    output logic                   Rx_PERROR,
    output logic                   Rx_FERROR,
    output logic                   Rx_VALID,
    output logic [$clog2(DEPTH):0] Rx_LEVEL,
    output logic                   Rx_OVERRUN
);
    localparam int unsigned ENT_W = DATA_BITS + 2;
    localparam logic [DIV_W-1:0] DIV_TAB [8] = '{
        baud_div(CLK_HZ, 3'd0), baud_div(CLK_HZ, 3'd1), baud_div(CLK_HZ, 3'd2), baud_div(CLK_HZ, 3'd3),
        baud_div(CLK_HZ, 3'd4), baud_div(CLK_HZ, 3'd5), baud_div(CLK_HZ, 3'd6), baud_div(CLK_HZ, 3'd7)
    };

    logic                 r_sync_meta, r_rx_s, r_rx_prev;
    logic [2:0]           r_state, w_state_nxt;
    logic [DIV_W-1:0]     r_div_cnt, w_div_cnt_nxt;
    logic [3:0]           r_tick_cnt, w_tick_cnt_nxt;
    logic [3:0]           r_bit_cnt, w_bit_cnt_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic                 r_perr, w_perr_nxt;
    logic                 r_ferr, w_ferr_nxt;
    logic                 r_wr_en, w_wr_en_nxt;
    logic                 r_armed, w_armed_nxt;
    logic [2:0]           r_baud_sel, w_baud_sel_nxt;
    logic [1:0]           r_par_mode, w_par_mode_nxt;
    logic                 r_overrun;
    logic                 w_tick, w_start, w_samp_en, w_bit, w_par_en, w_full;
    logic [ENT_W-1:0]     w_head;

    assign w_tick   = (r_div_cnt == (DIV_TAB[r_baud_sel] - DIV_W'(1)));
    assign w_start  = r_armed & r_rx_prev & ~r_rx_s;
    assign w_par_en = (r_par_mode == PAR_EVEN) || (r_par_mode == PAR_ODD);

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_maj;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_maj <= '0;
        end else if (w_tick && ((r_tick_cnt == 4'd6) || (r_tick_cnt == 4'd7))) begin
            r_maj <= {r_maj[0], r_rx_s};
        end
    end

    assign w_samp_en = w_tick && (r_tick_cnt == 4'd8);
    assign w_bit     = (r_maj[1] & r_maj[0]) | (r_maj[1] & r_rx_s) | (r_maj[0] & r_rx_s);
`else
    assign w_samp_en = w_tick && (r_tick_cnt == 4'd7);
    assign w_bit     = r_rx_s;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_div_cnt_nxt  = r_div_cnt + DIV_W'(1);
        w_tick_cnt_nxt = r_tick_cnt;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_perr_nxt     = r_perr;
        w_ferr_nxt     = r_ferr;
        w_wr_en_nxt    = 1'b0;
        w_armed_nxt    = r_armed;
        w_baud_sel_nxt = r_baud_sel;
        w_par_mode_nxt = r_par_mode;
        if (w_tick) begin
            w_div_cnt_nxt  = '0;
            w_tick_cnt_nxt = r_tick_cnt + 4'd1;
        end
        case (r_state)
            ST_IDLE: begin
                // Oversample phase restarts from the detected start edge
                w_div_cnt_nxt  = '0;
                w_tick_cnt_nxt = '0;
                w_armed_nxt    = r_armed | r_rx_s;
                if (w_start) begin
                    w_state_nxt    = ST_START;
                    w_baud_sel_nxt = baud_select;
                    w_par_mode_nxt = parity_mode;
                    w_bit_cnt_nxt  = '0;
                    w_perr_nxt     = 1'b0;
                    w_ferr_nxt     = 1'b0;
                end
            end
            ST_START: begin
                if (w_samp_en) w_state_nxt = w_bit ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (w_samp_en) begin
                    w_shift_nxt   = {w_bit, r_shift[DATA_BITS-1:1]};
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'(DATA_BITS - 1)) w_state_nxt = w_par_en ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (w_samp_en) begin
                    w_perr_nxt  = w_bit ^ (^r_shift) ^ (r_par_mode == PAR_ODD);
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                // A low stop bit must see the line return high before the next start is accepted
                if (w_samp_en) begin
                    w_ferr_nxt  = ~w_bit;
                    w_armed_nxt = w_bit;
                    w_wr_en_nxt = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (!Rx_EN) begin
            w_state_nxt = ST_IDLE;
            w_wr_en_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync_meta <= 1'b1;
            r_rx_s      <= 1'b1;
            r_rx_prev   <= 1'b1;
            r_state     <= ST_IDLE;
            r_div_cnt   <= '0;
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
            r_wr_en     <= 1'b0;
            r_armed     <= 1'b0;
            r_baud_sel  <= '0;
            r_par_mode  <= '0;
        end else begin
            r_sync_meta <= RxD;
            r_rx_s      <= r_sync_meta;
            r_rx_prev   <= r_rx_s;
            r_state     <= w_state_nxt;
            r_div_cnt   <= w_div_cnt_nxt;
            r_tick_cnt  <= w_tick_cnt_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_perr      <= w_perr_nxt;
            r_ferr      <= w_ferr_nxt;
            r_wr_en     <= w_wr_en_nxt;
            r_armed     <= w_armed_nxt;
            r_baud_sel  <= w_baud_sel_nxt;
            r_par_mode  <= w_par_mode_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || !Rx_EN) begin
            r_overrun <= 1'b0;
        end else if (r_wr_en && w_full && !(Rx_RD && Rx_VALID)) begin
            r_overrun <= 1'b1;
        end
    end

    uart_sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (reset),
        .i_wr     (r_wr_en),
        .i_wdata  ({r_ferr, r_perr, r_shift}),
        .i_rd     (Rx_RD),
        .o_rdata  (w_head),
        .o_valid  (Rx_VALID),
        .o_full_c (w_full),
        .o_level  (Rx_LEVEL)
    );

    assign Rx_DATA    = w_head[DATA_BITS-1:0];
    assign Rx_PERROR  = w_head[DATA_BITS];
    assign Rx_FERROR  = w_head[DATA_BITS+1];
    assign Rx_OVERRUN = r_overrun;

endmodule
